ll_walker: RTL and testbench

- Parametrised linked-list pointer-sequence generator; successor to the fixed 16-node walker.
- Holds a runtime-writable next-pointer table. Accepts start pointers over a valid/ready handshake and streams each list's node pointers with output backpressure.
- Reports length and termination status per list.
- Sits between the list-configuration source and pointer consumers in the request-generation path.

---
 rtl/ll_pkg.sv | 26 ++
 rtl/ll_next_table.sv | 42 ++++
 rtl/ll_walker.sv | 164 ++++++++++++++++
 tb/tb_ll_walker.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ll_pkg                                                  |
// | Description : Shared types and constants for the linked-list walker: |
// |               null pointer, pointer type, FSM state encoding and     |
// |               the derived list-length width.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ll_pkg;

    localparam int LL_N     = 16;
    localparam int LL_WIDTH = $clog2(LL_N);
    localparam int LL_LEN_W = LL_WIDTH + 1;

    // Entry 0 of the table is the null pointer that terminates every list
    localparam int LL_NULL = 0;

    typedef logic [LL_WIDTH-1:0] ptr_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ll_next_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ll_next_table                                           |
// | Description : N x WIDTH next-pointer table. One write port (writes   |
// |               to the null entry are dropped) and two asynchronous    |
// |               read ports, so a pointer and its successor's successor |
// |               can be looked up in the same cycle.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ll_next_table #(
    parameter int N     = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [WIDTH-1:0] i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_next [N];

    // Table storage; entry 0 is never written so it always reads as null
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_next[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_next[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_next[i_raddr_a];
    assign o_rdata_b = r_next[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/ll_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ll_walker                                               |
// | Description : Linked-list pointer-sequence generator. Accepts list   |
// |               heads, streams node pointers with backpressure and     |
// |               reports length / loop-termination per list.            |
// |               Optional macro LL_WALKER_LOOP_DETECT_EN bounds walks   |
// |               on cyclic tables to N-1 elements and flags done_err.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ll_walker
    import ll_pkg::*;
#(
    parameter int N     = LL_N,
    parameter int WIDTH = $clog2(N),
    parameter int LEN_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_next,
    input  logic             start_vld,
    output logic             start_rdy,
    input  logic [WIDTH-1:0] start_ptr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_ptr,
    output logic             out_last,
    output logic             done_vld,
    output logic [LEN_W-1:0] done_len,
    output logic             done_err
);

    localparam logic [WIDTH-1:0] c_NULL = WIDTH'(LL_NULL);

    state_t           r_state;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_ptr;
    logic             r_out_last;
    logic             r_err;
    logic [LEN_W-1:0] r_hop;
    logic             r_pend_empty;
    logic             r_done_vld;
    logic [LEN_W-1:0] r_done_len;
    logic             r_done_err;

    logic             w_fire;
    logic             w_end;
    logic             w_cfg_we;
    logic             w_start;
    logic             w_start_nz;
    logic             w_start_z;
    logic             w_load;
    logic             w_loop;
    logic [WIDTH-1:0] w_addr_a;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_ld_ptr;
    logic [WIDTH-1:0] w_ld_next;
    logic [LEN_W-1:0] w_hop_inc;
    logic [LEN_W-1:0] w_ld_hop;

    assign w_fire   = r_out_vld & out_rdy;
    assign w_end    = w_fire & r_out_last;
    assign cfg_rdy  = (r_state == S_IDLE);
    assign w_cfg_we = cfg_vld & cfg_rdy;

    // An empty-list start colliding with a list end defers its done pulse by
    // one cycle; further starts are held off until that pulse has gone out.
    assign start_rdy  = ~cfg_vld & ~r_pend_empty & ((r_state == S_IDLE) | w_end);
    assign w_start    = start_vld & start_rdy;
    assign w_start_nz = w_start & (start_ptr != c_NULL);
    assign w_start_z  = w_start & (start_ptr == c_NULL);
    assign w_load     = w_start_nz | (w_fire & ~r_out_last);

    // Port A looks up the successor of the element being left (or of the new
    // head); port B chains off it to find whether the loaded element is last.
    assign w_addr_a  = w_start ? start_ptr : r_out_ptr;
    assign w_ld_ptr  = w_start ? start_ptr : w_rd_a;
    assign w_ld_next = w_start ? w_rd_a    : w_rd_b;

    assign w_hop_inc = (r_hop == {LEN_W{1'b1}}) ? r_hop : r_hop + LEN_W'(1);
    assign w_ld_hop  = w_start ? LEN_W'(1) : w_hop_inc;

`ifdef LL_WALKER_LOOP_DETECT_EN
    assign w_loop = (w_ld_hop == LEN_W'(N - 1)) & (w_ld_next != c_NULL);
`else
    assign w_loop = 1'b0;
`endif

    ll_next_table #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_cfg_we),
        .i_waddr   (cfg_addr),
        .i_wdata   (cfg_next),
        .i_raddr_a (w_addr_a),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Walk FSM: load heads, advance on accepted elements, emit done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_out_vld    <= 1'b0;
            r_out_ptr    <= '0;
            r_out_last   <= 1'b0;
            r_err        <= 1'b0;
            r_hop        <= '0;
            r_pend_empty <= 1'b0;
            r_done_vld   <= 1'b0;
            r_done_len   <= '0;
            r_done_err   <= 1'b0;
        end else begin
            r_done_vld <= 1'b0;
            if (r_pend_empty) begin
                r_done_vld   <= 1'b1;
                r_done_len   <= '0;
                r_done_err   <= 1'b0;
                r_pend_empty <= 1'b0;
            end
            if (w_end) begin
                r_done_vld <= 1'b1;
                r_done_len <= r_hop;
                r_done_err <= r_err;
                if (w_start_z) begin
                    r_pend_empty <= 1'b1;
                end
            end else if (w_start_z) begin
                r_done_vld <= 1'b1;
                r_done_len <= '0;
                r_done_err <= 1'b0;
            end

            if (w_load) begin
                r_state    <= S_WALK;
                r_out_vld  <= 1'b1;
                r_out_ptr  <= w_ld_ptr;
                r_out_last <= (w_ld_next == c_NULL) | w_loop;
                r_err      <= w_loop;
                r_hop      <= w_ld_hop;
            end else if (w_end) begin
                r_state   <= S_IDLE;
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_ptr  = r_out_ptr;
    assign out_last = r_out_last;
    assign done_vld = r_done_vld;
    assign done_len = r_done_len;
    assign done_err = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_ll_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ll_walker                                            |
// | Description : Self-checking bench for ll_walker: directed sequences, |
// |               a vector table and randomized acyclic tables checked   |
// |               against a list-walking reference model.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ll_walker;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_vld;
    logic          cfg_rdy;
    logic [W-1:0]  cfg_addr;
    logic [W-1:0]  cfg_next;
    logic          start_vld;
    logic          start_rdy;
    logic [W-1:0]  start_ptr;
    logic          out_vld;
    logic          out_rdy;
    logic [W-1:0]  out_ptr;
    logic          out_last;
    logic          done_vld;
    logic [LW-1:0] done_len;
    logic          done_err;

    always #5 clk = ~clk;

    ll_walker #(.N(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_vld   (cfg_vld),
        .cfg_rdy   (cfg_rdy),
        .cfg_addr  (cfg_addr),
        .cfg_next  (cfg_next),
        .start_vld (start_vld),
        .start_rdy (start_rdy),
        .start_ptr (start_ptr),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_ptr   (out_ptr),
        .out_last  (out_last),
        .done_vld  (done_vld),
        .done_len  (done_len),
        .done_err  (done_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct { logic [W-1:0] ptr; logic last; } elem_t;
    typedef struct { int len; logic err; } done_t;
    typedef struct { int head; int mode; int len; int first; int lastp; } vec_t;

    elem_t        exp_q[$];
    done_t        done_q[$];
    logic [W-1:0] tbl [N];
    bit           sb_en = 1'b1;
    int           rdy_mode = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_ptr;
    logic         prev_last;
    elem_t        m_e;
    done_t        m_d;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: required event did not occur as expected", name);
    endtask

    // Reference: follow the model table from the head until the null pointer
    function automatic void model_start(input logic [W-1:0] head);
        logic [W-1:0] p;
        logic [W-1:0] nx;
        int           n;
        logic         last;
        logic         e_err;
        elem_t        e;
        done_t        d;
        p = head; n = 0; e_err = 1'b0;
        while (p != 0 && n < 200) begin
            n++;
            nx   = tbl[p];
            last = (nx == 0);
`ifdef LL_WALKER_LOOP_DETECT_EN
            if (n == N - 1 && !last) begin
                last  = 1'b1;
                e_err = 1'b1;
            end
`endif
            e.ptr = p; e.last = last;
            exp_q.push_back(e);
            if (last) break;
            p = nx;
        end
        d.len = n; d.err = e_err;
        done_q.push_back(d);
    endfunction

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            done_q.delete();
            for (int i = 0; i < N; i++) tbl[i] = '0;
            prev_stall = 1'b0;
        end else begin
            if (cfg_vld && cfg_rdy && cfg_addr != 0) tbl[cfg_addr] = cfg_next;
            if (start_vld && start_rdy && sb_en) model_start(start_ptr);
            if (prev_stall) begin
                chk("hold_vld", int'(out_vld), 1);
                chk("hold_ptr", int'(out_ptr), int'(prev_ptr));
                chk("hold_last", int'(out_last), int'(prev_last));
            end
            if (sb_en && out_vld && out_rdy) begin
                if (exp_q.size() == 0) flag_fail("sb_unexpected_out");
                else begin
                    m_e = exp_q.pop_front();
                    chk("sb_out_ptr", int'(out_ptr), int'(m_e.ptr));
                    chk("sb_out_last", int'(out_last), int'(m_e.last));
                end
            end
            if (sb_en && done_vld) begin
                if (done_q.size() == 0) flag_fail("sb_unexpected_done");
                else begin
                    m_d = done_q.pop_front();
                    chk("sb_done_len", int'(done_len), m_d.len);
                    chk("sb_done_err", int'(done_err), int'(m_d.err));
                end
            end
            prev_stall = out_vld && !out_rdy;
            prev_ptr   = out_ptr;
            prev_last  = out_last;
        end
    end

    // Consumer ready pattern: 0 always, 1 random, 2 1-0-0 cycle, 3 stalled
    initial begin
        int ph;
        ph = 0;
        out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ($urandom_range(0, 3) != 0);
                2: begin out_rdy = (ph % 3 == 0); ph++; end
                default: out_rdy = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_cfg(input int a, input int nx);
        bit acc;
        acc = 1'b0;
        cfg_vld = 1'b1; cfg_addr = W'(a); cfg_next = W'(nx);
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk); acc = cfg_rdy; step();
        end
        cfg_vld = 1'b0;
        if (!acc) flag_fail("cfg_timeout");
    endtask

    task automatic do_start(input int p);
        bit acc;
        acc = 1'b0;
        start_vld = 1'b1; start_ptr = W'(p);
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk); acc = start_rdy; step();
        end
        start_vld = 1'b0;
        if (!acc) flag_fail("start_timeout");
    endtask

    task automatic run_capture(input int head, output int len, output int first,
                               output int lastp, output int err);
        bit got;
        bit seen;
        got = 1'b0; seen = 1'b0;
        len = -1; first = 0; lastp = 0; err = -1;
        do_start(head);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                if (!seen) first = int'(out_ptr);
                seen  = 1'b1;
                lastp = int'(out_ptr);
            end
            if (done_vld) begin
                got = 1'b1; len = int'(done_len); err = int'(done_err);
            end
            step();
        end
        if (!got) flag_fail("done_timeout");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || done_q.size() != 0); i++) step();
        chk("drain_left", exp_q.size() + done_q.size(), 0);
    endtask

    task automatic load_plan_table();
        do_cfg(1, 5);  do_cfg(5, 3);   do_cfg(3, 10);
        do_cfg(2, 4);
        do_cfg(7, 15); do_cfg(15, 8);
        do_cfg(9, 14); do_cfg(14, 11); do_cfg(11, 13); do_cfg(13, 12);
    endtask

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] s7[3];
        logic         l7[3];
        int           len, first, lastp, err, bad, nx;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] s7[3];
        logic         l7[3];
        int           len, first, lastp, err, bad, nx;

        rst = 1'b0; cfg_vld = 1'b0; cfg_addr = '0; cfg_next = '0;
        start_vld = 1'b0; start_ptr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_out_ptr", int'(out_ptr), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done_vld", int'(done_vld), 0);
        chk("rst_done_len", int'(done_len), 0);
        chk("rst_done_err", int'(done_err), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cfg_rdy", int'(cfg_rdy), 1);
        chk("idle_start_rdy", int'(start_rdy), 1);
        step();

        load_plan_table();

        // Head 7: one-cycle latency, then 7,15,8 back to back, done len 3
        s7[0] = 4'd7; s7[1] = 4'd15; s7[2] = 4'd8;
        l7[0] = 1'b0; l7[1] = 1'b0; l7[2] = 1'b1;
        start_vld = 1'b1; start_ptr = 4'd7;
        @(negedge clk); chk("l7_start_rdy", int'(start_rdy), 1); step();
        start_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("l7_vld", int'(out_vld), 1);
            chk("l7_ptr", int'(out_ptr), int'(s7[i]));
            chk("l7_last", int'(out_last), int'(l7[i]));
            chk("l7_no_done", int'(done_vld), 0);
            step();
        end
        @(negedge clk);
        chk("l7_done", int'(done_vld), 1);
        chk("l7_len", int'(done_len), 3);
        chk("l7_vld_off", int'(out_vld), 0);
        step();

        // Heads 6 then 2 with zero bubble
        start_vld = 1'b1; start_ptr = 4'd6;
        @(negedge clk); chk("b2b_rdy0", int'(start_rdy), 1); step();
        start_ptr = 4'd2;
        @(negedge clk);
        chk("b2b_ptr6", int'(out_ptr), 6); chk("b2b_last6", int'(out_last), 1);
        chk("b2b_rdy1", int'(start_rdy), 1);
        step();
        start_vld = 1'b0;
        @(negedge clk);
        chk("b2b_vld2", int'(out_vld), 1); chk("b2b_ptr2", int'(out_ptr), 2);
        chk("b2b_done1", int'(done_vld), 1); chk("b2b_len1", int'(done_len), 1);
        step();
        @(negedge clk);
        chk("b2b_ptr4", int'(out_ptr), 4); chk("b2b_last4", int'(out_last), 1);
        chk("b2b_gap", int'(done_vld), 0);
        step();
        @(negedge clk);
        chk("b2b_done2", int'(done_vld), 1); chk("b2b_len2", int'(done_len), 2);
        chk("b2b_vld_off", int'(out_vld), 0);
        step();

        // Empty list
        start_vld = 1'b1; start_ptr = 4'd0;
        @(negedge clk); chk("empty_rdy", int'(start_rdy), 1); step();
        start_vld = 1'b0;
        @(negedge clk);
        chk("empty_done", int'(done_vld), 1); chk("empty_len", int'(done_len), 0);
        chk("empty_err", int'(done_err), 0); chk("empty_no_out", int'(out_vld), 0);
        step();
        @(negedge clk); chk("empty_pulse_1cyc", int'(done_vld), 0); step();

        // Config write beats start; write to address 0 dropped
        cfg_vld = 1'b1; cfg_addr = 4'd0; cfg_next = 4'd5;
        start_vld = 1'b1; start_ptr = 4'd6;
        @(negedge clk);
        chk("prio_cfg_rdy", int'(cfg_rdy), 1); chk("prio_start_blocked", int'(start_rdy), 0);
        step();
        cfg_vld = 1'b0;
        @(negedge clk); chk("prio_start_next", int'(start_rdy), 1); step();
        start_vld = 1'b0;
        chk("null_entry", int'(u_dut.u_table.r_next[0]), 0);
        wait_drain();

        // Vector table: {head, ready mode, len, first, last}
        vecs[0] = '{7, 1, 3, 7, 8};
        vecs[1] = '{6, 1, 1, 6, 6};
        vecs[2] = '{2, 1, 2, 2, 4};
        vecs[3] = '{9, 2, 5, 9, 12};
        vecs[4] = '{1, 1, 4, 1, 10};
        vecs[5] = '{0, 1, 0, 0, 0};
        vecs[6] = '{14, 3 - 2, 4, 14, 12};
        vecs[7] = '{15, 2, 2, 15, 8};
        foreach (vecs[i]) begin
            rdy_mode = vecs[i].mode;
            run_capture(vecs[i].head, len, first, lastp, err);
            chk("vec_len", len, vecs[i].len);
            chk("vec_first", first, vecs[i].first);
            chk("vec_last", lastp, vecs[i].lastp);
            chk("vec_err", err, 0);
            wait_drain();
        end

        // Random acyclic tables with random heads and random backpressure
        for (int it = 0; it < 3; it++) begin
            rdy_mode = 0;
            for (int a = 1; a < N; a++) begin
                nx = (a == N - 1 || $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(a + 1, N - 1));
                do_cfg(a, nx);
            end
            rdy_mode = 1;
            for (int k = 0; k < 10; k++) do_start(int'($urandom_range(0, N - 1)));
            wait_drain();
        end

        // Cyclic table 1 -> 2 -> 1
        rdy_mode = 0;
        do_cfg(1, 2); do_cfg(2, 1);
`ifdef LL_WALKER_LOOP_DETECT_EN
        run_capture(1, len, first, lastp, err);
        chk("loop_len", len, N - 1);
        chk("loop_first", first, 1);
        chk("loop_last", lastp, 1);
        chk("loop_err", err, 1);
        wait_drain();
`else
        sb_en = 1'b0;
        do_start(1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_vld || out_last || done_vld) bad++;
            step();
        end
        chk("cyclic_stream", bad, 0);
        #2; rst = 1'b0; #1;
        chk("cyclic_rst_vld", int'(out_vld), 0);
        step(); rst = 1'b1;
        sb_en = 1'b1;
`endif

        // Reset mid-walk aborts with no done pulse
        rst = 1'b0; step(); rst = 1'b1;
        do_cfg(9, 14); do_cfg(14, 11); do_cfg(11, 13); do_cfg(13, 12);
        rdy_mode = 3;
        do_start(9);
        step(); step();
        chk("midrst_walking", int'(out_vld), 1);
        #2; rst = 1'b0; #1;
        chk("midrst_vld", int'(out_vld), 0);
        chk("midrst_ptr", int'(out_ptr), 0);
        step(); rst = 1'b1;
        rdy_mode = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_vld || out_vld) bad++;
            step();
        end
        chk("midrst_no_done", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
